ct_rtu_preg_freelist_64: RTL and testbench
==========================================

# ct_rtu_preg_freelist_64

Free-list allocator for a 64-entry physical register pool in the retire unit. It tracks which entries are free, holds one pre-selected entry ready for allocation, and grants it to a single requester per cycle with a valid/ready handshake. Retire releases entries back to the pool as a multi-hot vector, and a flush reloads the whole pool from a recovery vector. The allocated entry is driven both one-hot and as a 6-bit index.

## Interface
- RST_BUSY, 32: entries [RST_BUSY-1:0] are allocated out of reset (architectural mapping); legal range 0..63.
- cpuclk  in  1  clock; all state on the rising edge.
- cpurst_b  in  1  reset; asynchronous assert, active-low.
- alloc_req  in  1  requester wants one entry this cycle.
- alloc_vld  out  1  a pre-selected entry is available.
- alloc_preg_expand  out  64  one-hot pre-selected entry; zero when alloc_vld=0.
- alloc_preg  out  6  binary index of alloc_preg_expand; 0 when alloc_vld=0.
- release_vld  in  1  release_expand is valid this cycle.
- release_expand  in  64  multi-hot entries returned to the pool.
- flush_vld  in  1  recover the pool.
- flush_free_vec  in  64  free vector to load on flush.
- free_cnt  out  7  free entries, including the pre-selected one.
- freelist_empty  out  1  free_cnt==0.

## Operation
- State: free_vec[63:0], excluding the pre-selected entry; prealloc_vld; prealloc_expand[63:0]; free_cnt[6:0].
- Grant: grant = alloc_req & alloc_vld. The requester samples alloc_preg and alloc_preg_expand in the grant cycle. There is no separate ready signal.
- Refill: when prealloc_vld=0, or grant=1, the lowest set bit of free_vec (find-first-one from bit 0) loads into prealloc_expand and is cleared from free_vec. If free_vec is zero, prealloc_vld goes to 0.
- Release: free_vec |= release_expand when release_vld=1. Released bits are eligible for refill from the next cycle, not the same cycle.
- free_cnt next value = free_cnt + popcount(release_expand & {64{release_vld}}) - grant. Saturation never occurs in legal use.
- Flush has priority over grant and release in the same cycle. Then free_vec = flush_free_vec, prealloc_vld=0, and free_cnt = popcount(flush_free_vec). Grant is suppressed; alloc_vld is forced to 0 during a flush cycle.
- Illegal inputs, flagged by assertions and undefined in the design:
  - releasing an entry already free;
  - releasing the pre-selected entry;
  - a non-one-hot prealloc.
- Width rules:
  - popcount is computed on 7 bits;
  - the index is the binary encoding of a one-hot vector, where an all-zero vector encodes to 0.

## Timing
- Reset values:
  - free_vec = ~((1<<RST_BUSY)-1);
  - prealloc_vld=0, alloc_vld=0, alloc_preg_expand=0, alloc_preg=0;
  - free_cnt=64-RST_BUSY; freelist_empty=(RST_BUSY==64).
- First cycle after reset deassertion: refill loads entry RST_BUSY. alloc_vld=1 from the second rising edge.
- Grant to next entry available: zero bubble. A back-to-back grant every cycle is supported while free_vec is non-empty.
- Release to grantable: one cycle when the pool was empty. The entry becomes pre-selected at the edge after the release, and alloc_vld=1 in the following cycle.
- Flush to alloc_vld: alloc_vld=0 in the flush cycle and the next cycle. It rises again two edges after flush if flush_free_vec is non-zero.
- Simultaneous grant of the last free entry and a release: free_cnt is updated as net. Refill uses free_vec from before the release, so alloc_vld drops for one cycle.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Outstanding grants are lost.

## Structure
- Shared package constants: PREG_NUM=64, PREG_IDX_W=6, PREG_CNT_W=7.
- Sub-module ct_rtu_ff1_64: combinational lowest-set-bit one-hot selector plus a 6-bit index encoder. The encoder is the existing one-hot-to-binary encoder.
- Top level: registers, the counter, and the flush/grant/release muxing. Target size is about 200 lines of RTL.

## Test plan
- Reset with RST_BUSY=32, then hold alloc_req=1 for 33 cycles:
  - grants indices 32,33,…,63 on consecutive cycles;
  - then alloc_vld=0, free_cnt=0, freelist_empty=1.
- Drain the pool, then release_expand=64'h0000_0000_0000_0005:
  - free_cnt=2 next cycle;
  - alloc_preg=0, then 2 on the following grants.
- Same-cycle grant and release of entry 7 with free_cnt=1: free_cnt stays 1, and alloc_vld shows a one-cycle gap before entry 7 is offered.
- Flush with flush_free_vec=64'hF000_0000_0000_0000 concurrent with alloc_req and release_vld:
  - no grant;
  - free_cnt=4;
  - first grant is index 60, two edges later.
- Assert cpurst_b low mid-stream: outputs return to reset values asynchronously before the next edge, and the first grant after release is index 32.
- Random alloc/release/flush run for 10k cycles:
  - free_cnt always equals popcount(free_vec)+prealloc_vld;
  - no index is granted twice without an intervening release or flush.

Source files
------------

// File: rtl/ct_rtu_preg_freelist_64_pkg.sv
// rtl/ct_rtu_preg_freelist_64_pkg.sv - shared constants and helpers for the preg free list
package ct_rtu_preg_freelist_64_pkg;

  localparam int PREG_NUM   = 64;
  localparam int PREG_IDX_W = 6;
  localparam int PREG_CNT_W = 7;

  function automatic logic [PREG_CNT_W-1:0] popcount64(input logic [PREG_NUM-1:0] v);
    logic [PREG_CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < PREG_NUM; i++) begin
      c = c + {{(PREG_CNT_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  // OR-reduction encoder: an all-zero vector encodes to 0.
  function automatic logic [PREG_IDX_W-1:0] onehot_encode(input logic [PREG_NUM-1:0] v);
    logic [PREG_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < PREG_NUM; i++) begin
      if (v[i]) begin
        idx = idx | PREG_IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/ct_rtu_ff1_64.sv
// rtl/ct_rtu_ff1_64.sv - lowest-set-bit one-hot selector with binary index
module ct_rtu_ff1_64
  import ct_rtu_preg_freelist_64_pkg::*;
(
  input  logic [PREG_NUM-1:0]   vec,
  output logic [PREG_NUM-1:0]   first_expand,
  output logic [PREG_IDX_W-1:0] first_idx,
  output logic                  found
);

  // Two's-complement isolate: keeps only the lowest set bit.
  assign first_expand = vec & (~vec + PREG_NUM'(1));
  assign first_idx    = onehot_encode(first_expand);
  assign found        = |vec;

endmodule

// File: rtl/ct_rtu_preg_freelist_64.sv
// rtl/ct_rtu_preg_freelist_64.sv - 64-entry physical register free-list allocator
module ct_rtu_preg_freelist_64
  import ct_rtu_preg_freelist_64_pkg::*;
#(
  parameter int RST_BUSY = 32
) (
  input  logic                  cpuclk,
  input  logic                  cpurst_b,
  input  logic                  alloc_req,
  output logic                  alloc_vld,
  output logic [PREG_NUM-1:0]   alloc_preg_expand,
  output logic [PREG_IDX_W-1:0] alloc_preg,
  input  logic                  release_vld,
  input  logic [PREG_NUM-1:0]   release_expand,
  input  logic                  flush_vld,
  input  logic [PREG_NUM-1:0]   flush_free_vec,
  output logic [PREG_CNT_W-1:0] free_cnt,
  output logic                  freelist_empty
);

  localparam logic [PREG_NUM-1:0] RST_FREE_VEC =
    (RST_BUSY >= PREG_NUM) ? '0 : ~((PREG_NUM'(1) << RST_BUSY) - PREG_NUM'(1));
  localparam logic [PREG_CNT_W-1:0] RST_FREE_CNT = PREG_CNT_W'(PREG_NUM - RST_BUSY);

  logic [PREG_NUM-1:0]   free_vec;
  logic                  prealloc_vld;
  logic [PREG_NUM-1:0]   prealloc_expand;

  logic [PREG_NUM-1:0]   free_vec_nxt;
  logic                  prealloc_vld_nxt;
  logic [PREG_NUM-1:0]   prealloc_expand_nxt;
  logic [PREG_CNT_W-1:0] free_cnt_nxt;

  logic [PREG_NUM-1:0]   ff1_expand;
  logic [PREG_IDX_W-1:0] ff1_idx;
  logic                  ff1_found;
  logic [PREG_NUM-1:0]   release_mask;
  logic                  grant;
  logic                  refill;

  ct_rtu_ff1_64 u_ff1 (
    .vec          (free_vec),
    .first_expand (ff1_expand),
    .first_idx    (ff1_idx),
    .found        (ff1_found)
  );

  assign alloc_vld         = prealloc_vld & ~flush_vld;
  assign grant             = alloc_req & alloc_vld;
  assign refill            = ~prealloc_vld | grant;
  assign release_mask      = release_expand & {PREG_NUM{release_vld}};
  assign alloc_preg_expand = alloc_vld ? prealloc_expand : '0;
  assign alloc_preg        = onehot_encode(alloc_preg_expand);
  assign freelist_empty    = (free_cnt == '0);

  // Refill picks from the pre-release free_vec, so released bits wait one cycle.
  always_comb begin
    free_vec_nxt        = free_vec | release_mask;
    prealloc_vld_nxt    = prealloc_vld;
    prealloc_expand_nxt = prealloc_expand;
    free_cnt_nxt        = free_cnt + popcount64(release_mask)
                          - {{(PREG_CNT_W-1){1'b0}}, grant};
    if (flush_vld) begin
      free_vec_nxt        = flush_free_vec;
      prealloc_vld_nxt    = 1'b0;
      prealloc_expand_nxt = '0;
      free_cnt_nxt        = popcount64(flush_free_vec);
    end else if (refill) begin
      free_vec_nxt        = (free_vec & ~ff1_expand) | release_mask;
      prealloc_vld_nxt    = ff1_found;
      prealloc_expand_nxt = ff1_expand;
    end
  end

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      free_vec        <= RST_FREE_VEC;
      prealloc_vld    <= 1'b0;
      prealloc_expand <= '0;
      free_cnt        <= RST_FREE_CNT;
    end else begin
      free_vec        <= free_vec_nxt;
      prealloc_vld    <= prealloc_vld_nxt;
      prealloc_expand <= prealloc_expand_nxt;
      free_cnt        <= free_cnt_nxt;
    end
  end

  a_release_not_free: assert property (@(posedge cpuclk) disable iff (!cpurst_b)
    (release_vld && !flush_vld) |-> ((release_expand & free_vec) == '0));

  a_release_not_prealloc: assert property (@(posedge cpuclk) disable iff (!cpurst_b)
    (release_vld && !flush_vld && prealloc_vld) |-> ((release_expand & prealloc_expand) == '0));

  a_prealloc_onehot: assert property (@(posedge cpuclk) disable iff (!cpurst_b)
    prealloc_vld |-> $onehot(prealloc_expand));

endmodule

// File: tb/tb_ct_rtu_preg_freelist_64.sv
// tb/tb_ct_rtu_preg_freelist_64.sv - self-checking bench for ct_rtu_preg_freelist_64
module tb_ct_rtu_preg_freelist_64;

  logic        cpuclk = 1'b0;
  logic        cpurst_b;
  logic        alloc_req;
  logic        alloc_vld;
  logic [63:0] alloc_preg_expand;
  logic [5:0]  alloc_preg;
  logic        release_vld;
  logic [63:0] release_expand;
  logic        flush_vld;
  logic [63:0] flush_free_vec;
  logic [6:0]  free_cnt;
  logic        freelist_empty;

  int total = 0;
  int bad   = 0;

  always #5 cpuclk = ~cpuclk;

  ct_rtu_preg_freelist_64 #(.RST_BUSY(32)) dut (
    .cpuclk            (cpuclk),
    .cpurst_b          (cpurst_b),
    .alloc_req         (alloc_req),
    .alloc_vld         (alloc_vld),
    .alloc_preg_expand (alloc_preg_expand),
    .alloc_preg        (alloc_preg),
    .release_vld       (release_vld),
    .release_expand    (release_expand),
    .flush_vld         (flush_vld),
    .flush_free_vec    (flush_free_vec),
    .free_cnt          (free_cnt),
    .freelist_empty    (freelist_empty)
  );

  typedef struct {
    logic       req;
    logic       exp_vld;
    logic [5:0] exp_preg;
    logic [6:0] exp_cnt;
  } vec_t;

  vec_t tbl[33];

  // Reference pool: free entries excluding the pre-selected one.
  bit pool[64];
  bit owned[64];
  bit dut_owned[64];
  bit pre_v;
  int pre_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic vld, input logic [5:0] preg,
                            input logic [6:0] cnt);
    logic [63:0] exp_expand;
    exp_expand = vld ? (64'd1 << preg) : 64'd0;
    chk({tag, ".alloc_vld"}, 64'(alloc_vld), 64'(vld));
    chk({tag, ".alloc_preg"}, 64'(alloc_preg), 64'(preg));
    chk({tag, ".alloc_preg_expand"}, alloc_preg_expand, exp_expand);
    chk({tag, ".free_cnt"}, 64'(free_cnt), 64'(cnt));
    chk({tag, ".freelist_empty"}, 64'(freelist_empty), 64'(cnt == 7'd0));
  endtask

  task automatic cyc();
    @(posedge cpuclk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      pool[i]      = (i >= 32);
      owned[i]     = (i < 32);
      dut_owned[i] = (i < 32);
    end
    pre_v = 1'b0;
    pre_i = 0;
  endtask

  function automatic int model_cnt();
    int c;
    c = pre_v ? 1 : 0;
    for (int i = 0; i < 64; i++) c += pool[i] ? 1 : 0;
    return c;
  endfunction

  task automatic model_edge();
    bit grant;
    int lo;
    if (flush_vld) begin
      for (int i = 0; i < 64; i++) begin
        pool[i]  = flush_free_vec[i];
        owned[i] = !flush_free_vec[i];
      end
      pre_v = 1'b0;
    end else begin
      grant = alloc_req && pre_v;
      if (grant) owned[pre_i] = 1'b1;
      if (!pre_v || grant) begin
        lo = -1;
        for (int i = 0; i < 64; i++) if (pool[i] && lo < 0) lo = i;
        if (lo >= 0) begin
          pool[lo] = 1'b0;
          pre_i    = lo;
          pre_v    = 1'b1;
        end else begin
          pre_v = 1'b0;
        end
      end
      if (release_vld) begin
        for (int i = 0; i < 64; i++) begin
          if (release_expand[i]) begin
            pool[i]  = 1'b1;
            owned[i] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic dut_owned_edge(input bit dut_grant, input logic [5:0] gidx);
    if (flush_vld) begin
      for (int i = 0; i < 64; i++) dut_owned[i] = !flush_free_vec[i];
    end else begin
      if (dut_grant) dut_owned[gidx] = 1'b1;
      if (release_vld) begin
        for (int i = 0; i < 64; i++) if (release_expand[i]) dut_owned[i] = 1'b0;
      end
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    cpurst_b       = 1'b0;
    alloc_req      = 1'b0;
    release_vld    = 1'b0;
    release_expand = '0;
    flush_vld      = 1'b0;
    flush_free_vec = '0;

    for (int i = 0; i < 33; i++) begin
      tbl[i].req      = 1'b1;
      tbl[i].exp_vld  = (i < 32);
      tbl[i].exp_preg = (i < 32) ? 6'(32 + i) : 6'd0;
      tbl[i].exp_cnt  = 7'(32 - i);
    end

    repeat (2) @(posedge cpuclk);
    @(negedge cpuclk);
    check_outs("reset", 1'b0, 6'd0, 7'd32);
    cyc();
    cpurst_b = 1'b1;
    cyc();

    // Drain the pool with back-to-back grants.
    for (int i = 0; i < 33; i++) begin
      alloc_req = tbl[i].req;
      @(negedge cpuclk);
      check_outs($sformatf("drain%0d", i), tbl[i].exp_vld, tbl[i].exp_preg, tbl[i].exp_cnt);
      cyc();
    end
    alloc_req = 1'b0;

    // Release into an empty pool.
    release_vld    = 1'b1;
    release_expand = 64'h0000_0000_0000_0005;
    @(negedge cpuclk);
    check_outs("rel0", 1'b0, 6'd0, 7'd0);
    cyc();
    release_vld = 1'b0;
    @(negedge cpuclk);
    check_outs("rel1", 1'b0, 6'd0, 7'd2);
    cyc();
    alloc_req = 1'b1;
    @(negedge cpuclk);
    check_outs("rel2", 1'b1, 6'd0, 7'd2);
    cyc();
    @(negedge cpuclk);
    check_outs("rel3", 1'b1, 6'd2, 7'd1);
    cyc();
    alloc_req = 1'b0;
    @(negedge cpuclk);
    check_outs("rel4", 1'b0, 6'd0, 7'd0);

    // Grant of the last entry together with a release of entry 7.
    cyc();
    release_vld    = 1'b1;
    release_expand = 64'd1 << 9;
    cyc();
    release_vld = 1'b0;
    @(negedge cpuclk);
    check_outs("g7pre", 1'b0, 6'd0, 7'd1);
    cyc();
    alloc_req      = 1'b1;
    release_vld    = 1'b1;
    release_expand = 64'd1 << 7;
    @(negedge cpuclk);
    check_outs("g7a", 1'b1, 6'd9, 7'd1);
    cyc();
    alloc_req   = 1'b0;
    release_vld = 1'b0;
    @(negedge cpuclk);
    check_outs("g7b", 1'b0, 6'd0, 7'd1);
    cyc();
    alloc_req = 1'b1;
    @(negedge cpuclk);
    check_outs("g7c", 1'b1, 6'd7, 7'd1);
    cyc();
    alloc_req = 1'b0;
    @(negedge cpuclk);
    check_outs("g7d", 1'b0, 6'd0, 7'd0);

    // Flush concurrent with a pending grant and a release.
    cyc();
    release_vld    = 1'b1;
    release_expand = 64'd1 << 10;
    cyc();
    release_vld = 1'b0;
    cyc();
    alloc_req      = 1'b1;
    release_vld    = 1'b1;
    release_expand = 64'd1 << 3;
    flush_vld      = 1'b1;
    flush_free_vec = 64'hF000_0000_0000_0000;
    @(negedge cpuclk);
    check_outs("fl0", 1'b0, 6'd0, 7'd1);
    cyc();
    flush_vld   = 1'b0;
    release_vld = 1'b0;
    @(negedge cpuclk);
    check_outs("fl1", 1'b0, 6'd0, 7'd4);
    cyc();
    @(negedge cpuclk);
    check_outs("fl2", 1'b1, 6'd60, 7'd4);
    cyc();
    @(negedge cpuclk);
    check_outs("fl3", 1'b1, 6'd61, 7'd3);

    // Asynchronous reset between edges.
    #2;
    cpurst_b = 1'b0;
    #1;
    check_outs("arst", 1'b0, 6'd0, 7'd32);
    cyc();
    cpurst_b = 1'b1;
    cyc();
    @(negedge cpuclk);
    check_outs("arst2", 1'b1, 6'd32, 7'd32);
    cyc();
    @(negedge cpuclk);
    check_outs("arst3", 1'b1, 6'd33, 7'd31);
    alloc_req = 1'b0;

    // Randomized run against the reference pool.
    cpurst_b = 1'b0;
    cyc();
    model_reset();
    cpurst_b = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      logic [63:0] rel;
      bit          dgrant;
      logic [5:0]  gidx;
      rel = '0;
      for (int i = 0; i < 64; i++) begin
        if (owned[i] && ($urandom_range(7) == 0)) rel[i] = 1'b1;
      end
      alloc_req      = ($urandom_range(3) != 0);
      release_vld    = ($urandom_range(1) == 0);
      release_expand = release_vld ? rel : 64'({$urandom, $urandom});
      if (!release_vld) release_expand = '0;
      flush_vld      = ($urandom_range(127) == 0);
      flush_free_vec = 64'({$urandom, $urandom}) & 64'({$urandom, $urandom});

      @(negedge cpuclk);
      check_outs($sformatf("rnd%0d", n), pre_v && !flush_vld,
                 (pre_v && !flush_vld) ? 6'(pre_i) : 6'd0, 7'(model_cnt()));
      dgrant = alloc_req && alloc_vld;
      gidx   = alloc_preg;
      if (dgrant) begin
        chk($sformatf("rnd%0d.dup_grant", n), 64'(dut_owned[gidx]), 64'd0);
      end
      @(posedge cpuclk);
      model_edge();
      dut_owned_edge(dgrant, gidx);
      #1;
    end
    alloc_req   = 1'b0;
    release_vld = 1'b0;
    flush_vld   = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
